ex_operand_stage: RTL
=====================

# ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU and supplies its `operand_a`, `operand_b`, `alu_control` and `shift_amount` inputs from registers. It captures decoded instructions from the decode stage under a valid/ready handshake and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result buses. It also refreshes held operands while stalled, and supports a pipeline flush for branch mispredicts.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU.
- `REG_ADDR_W`, 5, register-file address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard the held entry and refuse capture this cycle.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_rs1_addr`, `in_rs2_addr`, `in_rd_addr` in REG_ADDR_W: source and destination registers.
- `in_rs1_data`, `in_rs2_data` in WIDTH: register-file read data.
- `in_imm` in WIDTH: sign-extended immediate.
- `in_use_imm` in 1: operand B and shift amount come from `in_imm`.
- `in_alu_control` in 5: ALU control word, passed through unchanged.
- `fwd_ex_valid` in 1, `fwd_ex_rd` in REG_ADDR_W, `fwd_ex_data` in WIDTH: EX/MEM result bus.
- `fwd_mem_valid` in 1, `fwd_mem_rd` in REG_ADDR_W, `fwd_mem_data` in WIDTH: MEM/WB result bus.
- `out_valid` out 1: operands valid for the ALU.
- `out_ready` in 1: EX consumer accepts this cycle.
- `out_operand_a`, `out_operand_b` out WIDTH: ALU operands.
- `out_shift_amount` out $clog2(WIDTH): ALU shift amount.
- `out_alu_control` out 5: ALU control word.
- `out_rd_addr` out REG_ADDR_W: destination register.

## Operation
- Single-entry register stage; no bypass path from input to output.
- `in_ready` = !rst && !flush && (!out_valid || out_ready).
- Capture occurs on `in_valid && in_ready`. On capture:
  - register the rs addresses, `in_use_imm`, `in_rd_addr` and `in_alu_control`;
  - set A = fwd(rs1, `in_rs1_data`);
  - set B = `in_use_imm` ? `in_imm` : fwd(rs2, `in_rs2_data`);
  - set shift = `in_use_imm` ? `in_imm[$clog2(WIDTH)-1:0]` : low bits of the forwarded rs2 value.
- fwd(r, d) priority:
  1. `fwd_ex_valid && fwd_ex_rd==r && r!=0` -> `fwd_ex_data`;
  2. else `fwd_mem_valid && fwd_mem_rd==r && r!=0` -> `fwd_mem_data`;
  3. else d.
- Register 0 is never forwarded; its value is the supplied read data.
- Refresh: while holding (`out_valid && !out_ready`, no flush), each cycle a forwarding bus matches a held source (nonzero):
  - A is rewritten with that bus value, using the same priority;
  - B and shift are rewritten likewise when `in_use_imm` was 0.
  - Non-matching cycles leave the operands unchanged.
- Release: `out_valid && out_ready` without a new capture clears `out_valid`. The data outputs hold their last value.
- Back-to-back: a release and a capture in the same cycle keep `out_valid` = 1 with the new contents.
- Flush has priority over everything. `out_valid` becomes 0 on the next edge and no capture happens that cycle.
- Reset sets all outputs to 0 (`out_valid`=0, operands=0, control=0, rd=0, shift=0). `in_ready` is 0 while `rst` is high.
- Reset mid-hold drops the entry. No state survives reset.

## Timing
- Latency is 1 cycle, from a capture edge to `out_valid` and the operands being visible.
- Throughput is 1 instruction per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`, `out_ready`, `flush` and `rst`. No other combinational input-to-output path exists.
- A refreshed operand appears on the output 1 cycle after the matching forwarding cycle.
- The consumer samples outputs only when `out_valid && out_ready`. Outputs are stable while `out_valid && !out_ready`, except for refresh updates.

## Structure
- Shared package `cpu_pkg` holds:
  - `WIDTH`, `REG_ADDR_W` and `SHAMT_W` = $clog2(WIDTH);
  - ALU control field constants: bit 4 logic/arith select, bits 3:2 arith op, bit 0 signed, plus the arith op encodings ADD=00, SUB=01, MUL=10, DIV=11;
  - a packed struct for the held entry (the addresses, `use_imm`, `alu_control`).
- One sub-module, `fwd_mux`: a combinational priority forwarding selector with inputs reg addr, regfile data and both forwarding buses, and output the selected data. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- No hazard: capture rs1=3 data 0x10, rs2=4 data 0x20, `in_use_imm`=0, control 5'b00000, `out_ready`=1 -> next cycle `out_valid`=1, A=0x10, B=0x20, shift=0.
- Priority: rs1=7 with `fwd_ex` rd=7 data 0xAAAA and `fwd_mem` rd=7 data 0xBBBB -> A=0xAAAA. Repeat with rs1=0 -> A = regfile data.
- Immediate: `in_use_imm`=1, imm=0xFFFF_FFE3, `fwd_ex` matching rs2 -> B=0xFFFF_FFE3, shift=3, and no forwarding is applied to B.
- Stall refresh: hold with `out_ready`=0 and rs2=9; pulse `fwd_mem` rd=9 data 0x1234_0005 -> the cycle after, B=0x1234_0005 and shift=5; outputs stay stable otherwise.
- Handshake: `in_valid` and `out_ready` both high for 8 cycles -> 8 outputs in order, `in_ready` continuously 1. With `out_ready`=0 -> `in_ready`=0 and the held entry is unchanged.
- Flush/reset: flush while holding with `in_valid`=1 -> `in_ready`=0 that cycle and `out_valid`=0 next. Assert `rst` mid-hold -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU datapath constants, ALU control field layout and the
//            held-entry record used by the ID/EX operand stage.
// Contents : WIDTH, REG_ADDR_W, SHAMT_W, ALU control field positions and
//            arithmetic op encodings, entry_t.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Datapath geometry; WIDTH must match the ALU.
  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SHAMT_W    = $clog2(WIDTH);

  // ALU control word layout.
  localparam int ALU_CTRL_W      = 5;
  localparam int ALU_LOGIC_SEL_B = 4;  // 1 = logic unit, 0 = arithmetic unit
  localparam int ALU_ARITH_OP_HI = 3;
  localparam int ALU_ARITH_OP_LO = 2;
  localparam int ALU_SIGNED_B    = 0;

  typedef enum logic [1:0] {
    ARITH_ADD = 2'b00,
    ARITH_SUB = 2'b01,
    ARITH_MUL = 2'b10,
    ARITH_DIV = 2'b11
  } arith_op_e;

  // Control portion of the instruction held in the stage. The operand
  // values themselves live in separate registers because they are rewritten
  // by the stall refresh independently of this record.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  use_imm;
    logic [ALU_CTRL_W-1:0] alu_control;
  } entry_t;

  // Extract the arithmetic op field from an ALU control word.
  function automatic arith_op_e alu_arith_op(input logic [ALU_CTRL_W-1:0] ctrl);
    return arith_op_e'(ctrl[ALU_ARITH_OP_HI:ALU_ARITH_OP_LO]);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Combinational priority forwarding selector for one source
//            register. EX/MEM result wins over MEM/WB; register 0 is never
//            forwarded.
// Ports    : reg_addr_i  - source register address
//            reg_data_i  - fallback data (regfile read or held operand)
//            ex_*_i      - EX/MEM result bus (valid, rd, data)
//            mem_*_i     - MEM/WB result bus (valid, rd, data)
//            data_o      - selected operand value
// Revision : 1.0 - initial release
// ============================================================================
module fwd_mux #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] reg_addr_i,
  input  logic [WIDTH-1:0]      reg_data_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [WIDTH-1:0]      ex_data_i,
  input  logic                  mem_valid_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [WIDTH-1:0]      mem_data_i,
  output logic [WIDTH-1:0]      data_o
);

  logic addr_nonzero;
  logic ex_hit;
  logic mem_hit;

  assign addr_nonzero = (reg_addr_i != '0);
  assign ex_hit       = ex_valid_i  && (ex_rd_i  == reg_addr_i) && addr_nonzero;
  assign mem_hit      = mem_valid_i && (mem_rd_i == reg_addr_i) && addr_nonzero;

  always_comb begin
    data_o = reg_data_i;
    if (ex_hit) begin
      data_o = ex_data_i;
    end else if (mem_hit) begin
      data_o = mem_data_i;
    end
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX register stage feeding the ALU. Captures decoded
//            instructions under valid/ready, resolves RAW hazards from the
//            EX/MEM and MEM/WB result buses, refreshes held operands while
//            stalled, and supports flush.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            flush              - drop held entry, block capture this cycle
//            in_valid/in_ready  - decode handshake
//            in_rs*/in_rd/in_imm/in_use_imm/in_alu_control - decoded fields
//            fwd_ex_*, fwd_mem_*- forwarding buses
//            out_valid/out_ready- EX handshake
//            out_operand_a/b, out_shift_amount, out_alu_control,
//            out_rd_addr        - registered ALU inputs
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5   // must equal cpu_pkg::REG_ADDR_W (entry_t)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  // Decode side
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_ADDR_W-1:0]      in_rs1_addr,
  input  logic [REG_ADDR_W-1:0]      in_rs2_addr,
  input  logic [REG_ADDR_W-1:0]      in_rd_addr,
  input  logic [WIDTH-1:0]           in_rs1_data,
  input  logic [WIDTH-1:0]           in_rs2_data,
  input  logic [WIDTH-1:0]           in_imm,
  input  logic                       in_use_imm,
  input  logic [4:0]                 in_alu_control,
  // Forwarding buses
  input  logic                       fwd_ex_valid,
  input  logic [REG_ADDR_W-1:0]      fwd_ex_rd,
  input  logic [WIDTH-1:0]           fwd_ex_data,
  input  logic                       fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0]      fwd_mem_rd,
  input  logic [WIDTH-1:0]           fwd_mem_data,
  // ALU side
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_operand_a,
  output logic [WIDTH-1:0]           out_operand_b,
  output logic [$clog2(WIDTH)-1:0]   out_shift_amount,
  output logic [4:0]                 out_alu_control,
  output logic [REG_ADDR_W-1:0]      out_rd_addr
);

  import cpu_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               valid_q, valid_d;
  entry_t             entry_q, entry_d;
  logic [WIDTH-1:0]   opa_q,   opa_d;
  logic [WIDTH-1:0]   opb_q,   opb_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;

  logic capture;
  logic hold;
  logic release_only;

  // The forwarding muxes are shared between capture and refresh: on a
  // capture they look at the incoming addresses and regfile data, otherwise
  // at the held addresses with the current operand as fallback. A refresh
  // with no bus match therefore rewrites the operand with itself.
  logic [REG_ADDR_W-1:0] rs1_sel;
  logic [REG_ADDR_W-1:0] rs2_sel;
  logic [WIDTH-1:0]      rs1_base;
  logic [WIDTH-1:0]      rs2_base;
  logic [WIDTH-1:0]      rs1_fwd;
  logic [WIDTH-1:0]      rs2_fwd;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign in_ready     = !rst && !flush && (!valid_q || out_ready);
  assign capture      = in_valid && in_ready;
  assign hold         = valid_q && !out_ready;
  assign release_only = valid_q && out_ready && !capture;

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  assign rs1_sel  = capture ? in_rs1_addr : entry_q.rs1;
  assign rs2_sel  = capture ? in_rs2_addr : entry_q.rs2;
  assign rs1_base = capture ? in_rs1_data : opa_q;
  assign rs2_base = capture ? in_rs2_data : opb_q;

  fwd_mux #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .reg_addr_i  (rs1_sel),
    .reg_data_i  (rs1_base),
    .ex_valid_i  (fwd_ex_valid),
    .ex_rd_i     (fwd_ex_rd),
    .ex_data_i   (fwd_ex_data),
    .mem_valid_i (fwd_mem_valid),
    .mem_rd_i    (fwd_mem_rd),
    .mem_data_i  (fwd_mem_data),
    .data_o      (rs1_fwd)
  );

  fwd_mux #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .reg_addr_i  (rs2_sel),
    .reg_data_i  (rs2_base),
    .ex_valid_i  (fwd_ex_valid),
    .ex_rd_i     (fwd_ex_rd),
    .ex_data_i   (fwd_ex_data),
    .mem_valid_i (fwd_mem_valid),
    .mem_rd_i    (fwd_mem_rd),
    .mem_data_i  (fwd_mem_data),
    .data_o      (rs2_fwd)
  );

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shamt_d = shamt_q;

    if (flush) begin
      // Data registers keep their last value; only the entry is dropped.
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d             = 1'b1;
      entry_d.rs1         = in_rs1_addr;
      entry_d.rs2         = in_rs2_addr;
      entry_d.rd          = in_rd_addr;
      entry_d.use_imm     = in_use_imm;
      entry_d.alu_control = in_alu_control;
      opa_d               = rs1_fwd;
      if (in_use_imm) begin
        opb_d   = in_imm;
        shamt_d = in_imm[SHAMT_W-1:0];
      end else begin
        opb_d   = rs2_fwd;
        shamt_d = rs2_fwd[SHAMT_W-1:0];
      end
    end else if (hold) begin
      opa_d = rs1_fwd;
      if (!entry_q.use_imm) begin
        opb_d   = rs2_fwd;
        shamt_d = rs2_fwd[SHAMT_W-1:0];
      end
    end else if (release_only) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      shamt_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shamt_q <= shamt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid        = valid_q;
  assign out_operand_a    = opa_q;
  assign out_operand_b    = opb_q;
  assign out_shift_amount = shamt_q;
  assign out_alu_control  = entry_q.alu_control;
  assign out_rd_addr      = entry_q.rd;

endmodule : ex_operand_stage
`default_nettype wire
